// File: rtl/prog_ctr_seq_pkg.sv
// Shared types for the program-counter sequencer: FSM states and the
// selector that picks where the next ProgCtr value comes from.
package prog_ctr_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALTED,
    ERR
  } pc_state_e;

  typedef enum logic [2:0] {
    HOLD,
    INC,
    TGT,
    POP,
    START
  } pc_src_e;

endpackage

// File: rtl/prog_ctr_seq_if.sv
// Control/status bundle between the decode stage (master) and the
// program-counter sequencer (slave).
interface prog_ctr_seq_if #(
  parameter int PC_W  = 8,
  parameter int OFS_W = 6
);
  logic             Start;
  logic             Stall;
  logic             Branch;
  logic             CondMet;
  logic             Relative;
  logic [PC_W-1:0]  Target;
  logic [OFS_W-1:0] Offset;
  logic             Call;
  logic             Ret;
  logic             Halt;
  logic [PC_W-1:0]  ProgCtr;
  logic             Running;
  logic             Done;
  logic             StackErr;

  modport master (
    output Start, Stall, Branch, CondMet, Relative, Target, Offset, Call, Ret, Halt,
    input  ProgCtr, Running, Done, StackErr
  );

  modport slave (
    input  Start, Stall, Branch, CondMet, Relative, Target, Offset, Call, Ret, Halt,
    output ProgCtr, Running, Done, StackErr
  );
endinterface

// File: rtl/prog_ctr_seq_ret_stack.sv
// LIFO return-address stack used by the sequencer for Call/Ret.
// The pointer is reset; the storage array is plain data and is not.
module ret_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         push,
  input  logic         pop,
  input  logic         clr,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  sp_q, sp_d;
  logic [AW-1:0] rd_idx;

  assign full   = (sp_q == (AW+1)'(DEPTH));
  assign empty  = (sp_q == '0);
  // Top of stack sits one below the pointer; wraps harmlessly when full.
  assign rd_idx = sp_q[AW-1:0] - AW'(1);
  assign dout   = mem_q[rd_idx];

  // Next pointer: clear beats push beats pop.
  always_comb begin
    sp_d = sp_q;
    if (clr)
      sp_d = '0;
    else if (push && !full)
      sp_d = sp_q + (AW+1)'(1);
    else if (pop && !empty)
      sp_d = sp_q - (AW+1)'(1);
  end

  // Pointer register, cleared asynchronously so a reset drops all entries.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)
      sp_q <= '0;
    else
      sp_q <= sp_d;
  end

  // Storage write at the current pointer.
  always_ff @(posedge Clk) begin
    if (push && !full && !clr)
      mem_q[sp_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/prog_ctr_seq.sv
// Program-counter sequencer: IDLE/RUN/HALTED/ERR FSM plus next-PC mux.
// Define PROG_CTR_STACK_EN to build the Call/Ret return stack; without it
// Call is an unconditional branch, Ret is ignored and StackErr is 0.
module prog_ctr_seq
  import prog_ctr_pkg::*;
#(
  parameter int              PC_W        = 8,
  parameter int              OFS_W       = 6,
  parameter logic [PC_W-1:0] START_ADDR  = '0,
  parameter int              STACK_DEPTH = 4
) (
  input  logic         Clk,
  input  logic         Reset,
  prog_ctr_seq_if.slave bus
);
  pc_state_e       state_q, state_d;
  pc_src_e         src;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] tgt;

  assign pc_inc = pc_q + PC_W'(1);
  // Size-casting the signed offset sign-extends it; the sum wraps mod 2^PC_W.
  assign tgt    = bus.Relative ? (pc_q + PC_W'($signed(bus.Offset))) : bus.Target;

`ifdef PROG_CTR_STACK_EN
  logic            stk_push, stk_pop, stk_full, stk_empty;
  logic [PC_W-1:0] stk_dout;

  ret_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (PC_W)
  ) u_ret_stack (
    .Clk   (Clk),
    .Reset (Reset),
    .push  (stk_push),
    .pop   (stk_pop),
    .clr   (bus.Start),
    .din   (pc_inc),
    .dout  (stk_dout),
    .full  (stk_full),
    .empty (stk_empty)
  );
`else
  logic            unused_ret;
  localparam int   unused_depth = STACK_DEPTH;
  assign unused_ret = bus.Ret;
`endif

  // Next state and next-PC source; Start overrides everything, then RUN priorities.
  always_comb begin
    state_d = state_q;
    src     = HOLD;
`ifdef PROG_CTR_STACK_EN
    stk_push = 1'b0;
    stk_pop  = 1'b0;
`endif
    if (bus.Start) begin
      state_d = RUN;
      src     = START;
    end else if (state_q == RUN) begin
      if (bus.Halt)
        state_d = HALTED;
      else if (bus.Stall)
        src = HOLD;
`ifdef PROG_CTR_STACK_EN
      else if (bus.Ret) begin
        if (stk_empty)
          state_d = ERR;
        else begin
          stk_pop = 1'b1;
          src     = POP;
        end
      end else if (bus.Call) begin
        if (stk_full)
          state_d = ERR;
        else begin
          stk_push = 1'b1;
          src      = TGT;
        end
      end
`else
      else if (bus.Call)
        src = TGT;
`endif
      else if (bus.Branch && bus.CondMet)
        src = TGT;
      else
        src = INC;
    end
  end

  // Next-PC mux.
  always_comb begin
    pc_d = pc_q;
    case (src)
      HOLD:    pc_d = pc_q;
      INC:     pc_d = pc_inc;
      TGT:     pc_d = tgt;
`ifdef PROG_CTR_STACK_EN
      POP:     pc_d = stk_dout;
`else
      POP:     pc_d = pc_q;
`endif
      START:   pc_d = START_ADDR;
      default: pc_d = pc_q;
    endcase
  end

  // State and PC registers with asynchronous active-low reset.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      pc_q    <= START_ADDR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign bus.ProgCtr = pc_q;
  assign bus.Running = (state_q == RUN);
  assign bus.Done    = (state_q == HALTED);
`ifdef PROG_CTR_STACK_EN
  assign bus.StackErr = (state_q == ERR);
`else
  assign bus.StackErr = 1'b0;
`endif
endmodule

// File: tb/tb_prog_ctr_seq.sv
// Self-checking bench for prog_ctr_seq. Directed scenarios and a random run
// are compared against a behavioural model kept as plain integers and a queue.
// Stack scenarios follow PROG_CTR_STACK_EN the same way the design does.
module tb_prog_ctr_seq;
  localparam int              PC_W        = 8;
  localparam int              OFS_W       = 6;
  localparam int              STACK_DEPTH = 4;
  localparam logic [PC_W-1:0] START_ADDR  = '0;
  localparam int              PC_MASK     = (1 << PC_W) - 1;
  localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2, M_ERR = 3;

  logic Clk;
  logic Reset;

  prog_ctr_seq_if #(.PC_W(PC_W), .OFS_W(OFS_W)) bus ();

  prog_ctr_seq #(
    .PC_W        (PC_W),
    .OFS_W       (OFS_W),
    .START_ADDR  (START_ADDR),
    .STACK_DEPTH (STACK_DEPTH)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks;
  int n_err;
  int m_pc;
  int m_mode;
  int m_stk[$];

  task automatic model_reset();
    m_pc   = int'(START_ADDR);
    m_mode = M_IDLE;
    m_stk.delete();
  endtask

  // One clock edge of the specified behaviour, from the inputs currently driven.
  task automatic model_step();
    int t;
    int o;
    if (bus.Start) begin
      m_mode = M_RUN;
      m_pc   = int'(START_ADDR);
      m_stk.delete();
      return;
    end
    if (m_mode != M_RUN) return;
    if (bus.Halt) begin
      m_mode = M_HALT;
      return;
    end
    if (bus.Stall) return;
    o = $signed(bus.Offset);
    t = bus.Relative ? ((m_pc + o) & PC_MASK) : int'(bus.Target);
`ifdef PROG_CTR_STACK_EN
    if (bus.Ret) begin
      if (m_stk.size() == 0) m_mode = M_ERR;
      else m_pc = m_stk.pop_back();
      return;
    end
    if (bus.Call) begin
      if (m_stk.size() == STACK_DEPTH) m_mode = M_ERR;
      else begin
        m_stk.push_back((m_pc + 1) & PC_MASK);
        m_pc = t;
      end
      return;
    end
`else
    if (bus.Call) begin
      m_pc = t;
      return;
    end
`endif
    if (bus.Branch && bus.CondMet) m_pc = t;
    else m_pc = (m_pc + 1) & PC_MASK;
  endtask

  function automatic logic [PC_W+2:0] exp_vec();
    return {PC_W'(m_pc), m_mode == M_RUN, m_mode == M_HALT, m_mode == M_ERR};
  endfunction

  task automatic clr_in();
    bus.Start = 0; bus.Stall = 0; bus.Branch = 0; bus.CondMet = 0;
    bus.Relative = 0; bus.Target = '0; bus.Offset = '0;
    bus.Call = 0; bus.Ret = 0; bus.Halt = 0;
  endtask

  task automatic tick();
    @(posedge Clk);
    if (Reset) model_step();
    else model_reset();
    #1;
  endtask

  task automatic go_to(input int pc);
    clr_in();
    bus.Branch = 1; bus.CondMet = 1; bus.Target = PC_W'(pc);
    tick();
    clr_in();
  endtask

  task automatic test_reset();
    Reset = 0;
    clr_in();
    model_reset();
    #1;
    n_checks++;
    if ({bus.ProgCtr, bus.Running, bus.Done, bus.StackErr} !== {START_ADDR, 3'b000}) begin
      n_err++;
      $display("FAIL reset_state: got pc=%0d flags=%b expected pc=%0d flags=000",
               bus.ProgCtr, {bus.Running, bus.Done, bus.StackErr}, START_ADDR);
    end
    tick(); tick();
    Reset = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({bus.ProgCtr, bus.Running, bus.Done, bus.StackErr} !== exp_vec()) begin
        n_err++;
        $display("FAIL idle_hold[%0d]: got %h expected %h", i,
                 {bus.ProgCtr, bus.Running, bus.Done, bus.StackErr}, exp_vec());
      end
    end
  endtask

  task automatic test_count();
    clr_in();
    bus.Start = 1;
    tick();
    clr_in();
    for (int i = 0; i <= 5; i++) begin
      if (i > 0) tick();
      n_checks++;
      if ({bus.ProgCtr, bus.Running, bus.Done, bus.StackErr} !== {PC_W'(i), 3'b100} ||
          exp_vec() !== {PC_W'(i), 3'b100}) begin
        n_err++;
        $display("FAIL count[%0d]: got pc=%0d run=%b expected pc=%0d run=1", i,
                 bus.ProgCtr, bus.Running, i);
      end
    end
  endtask

  task automatic test_branch();
    go_to(10);
    bus.Branch = 1; bus.CondMet = 1; bus.Relative = 1; bus.Offset = 6'h3C;
    tick();
    n_checks++;
    if (bus.ProgCtr !== 8'd6 || exp_vec() !== {8'd6, 3'b100}) begin
      n_err++;
      $display("FAIL rel_branch_taken: got pc=%0d expected pc=6", bus.ProgCtr);
    end
    go_to(10);
    bus.Branch = 1; bus.CondMet = 0; bus.Relative = 1; bus.Offset = 6'h3C;
    tick();
    n_checks++;
    if (bus.ProgCtr !== 8'd11) begin
      n_err++;
      $display("FAIL rel_branch_not_taken: got pc=%0d expected pc=11", bus.ProgCtr);
    end
    go_to(250);
    bus.Branch = 1; bus.CondMet = 1; bus.Relative = 1; bus.Offset = 6'd10;
    tick();
    n_checks++;
    if (bus.ProgCtr !== 8'd4) begin
      n_err++;
      $display("FAIL rel_branch_wrap: got pc=%0d expected pc=4", bus.ProgCtr);
    end
    clr_in();
  endtask

  task automatic test_wrap_stall();
    go_to(255);
    tick();
    n_checks++;
    if (bus.ProgCtr !== 8'd0 || bus.Running !== 1'b1) begin
      n_err++;
      $display("FAIL inc_wrap: got pc=%0d run=%b expected pc=0 run=1", bus.ProgCtr, bus.Running);
    end
    go_to(7);
    bus.Stall = 1; bus.Branch = 1; bus.CondMet = 1; bus.Target = 8'd99; bus.Call = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (bus.ProgCtr !== 8'd7 || exp_vec() !== {8'd7, 3'b100}) begin
        n_err++;
        $display("FAIL stall[%0d]: got pc=%0d expected pc=7", i, bus.ProgCtr);
      end
    end
    clr_in();
    tick();
    n_checks++;
    if (bus.ProgCtr !== 8'd8) begin
      n_err++;
      $display("FAIL stall_release: got pc=%0d expected pc=8", bus.ProgCtr);
    end
  endtask

  task automatic test_call();
    clr_in();
    bus.Start = 1;
    tick();
    clr_in();
    tick(); tick(); tick();
    bus.Call = 1; bus.Target = 8'd40;
    tick();
    clr_in();
    n_checks++;
    if (bus.ProgCtr !== 8'd40 || bus.StackErr !== 1'b0) begin
      n_err++;
      $display("FAIL call_target: got pc=%0d err=%b expected pc=40 err=0", bus.ProgCtr, bus.StackErr);
    end
    bus.Ret = 1;
    tick();
    clr_in();
`ifdef PROG_CTR_STACK_EN
    n_checks++;
    if (bus.ProgCtr !== 8'd4) begin
      n_err++;
      $display("FAIL ret_pop: got pc=%0d expected pc=4", bus.ProgCtr);
    end
    for (int i = 0; i < 5; i++) begin
      bus.Call = 1; bus.Target = PC_W'(50 + i);
      tick();
      n_checks++;
      if ({bus.ProgCtr, bus.Running, bus.Done, bus.StackErr} !== exp_vec()) begin
        n_err++;
        $display("FAIL nested_call[%0d]: got %h expected %h", i,
                 {bus.ProgCtr, bus.Running, bus.Done, bus.StackErr}, exp_vec());
      end
    end
    clr_in();
    bus.Branch = 1; bus.CondMet = 1; bus.Target = 8'd77;
    tick(); tick();
    clr_in();
    n_checks++;
    if ({bus.ProgCtr, bus.Running, bus.StackErr} !== {8'd53, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL overflow_frozen: got pc=%0d run=%b err=%b expected pc=53 run=0 err=1",
               bus.ProgCtr, bus.Running, bus.StackErr);
    end
    bus.Start = 1;
    tick();
    clr_in();
    n_checks++;
    if ({bus.ProgCtr, bus.Running, bus.StackErr} !== {8'd0, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL err_restart: got pc=%0d run=%b err=%b expected pc=0 run=1 err=0",
               bus.ProgCtr, bus.Running, bus.StackErr);
    end
    tick();
    bus.Ret = 1;
    tick();
    clr_in();
    n_checks++;
    if ({bus.ProgCtr, bus.StackErr} !== {8'd1, 1'b1} || exp_vec() !== {8'd1, 3'b001}) begin
      n_err++;
      $display("FAIL underflow: got pc=%0d err=%b expected pc=1 err=1", bus.ProgCtr, bus.StackErr);
    end
    bus.Start = 1;
    tick();
    clr_in();
`else
    n_checks++;
    if (bus.ProgCtr !== 8'd41 || bus.StackErr !== 1'b0) begin
      n_err++;
      $display("FAIL ret_ignored: got pc=%0d err=%b expected pc=41 err=0", bus.ProgCtr, bus.StackErr);
    end
`endif
  endtask

  task automatic test_halt();
    go_to(20);
    bus.Halt = 1;
    tick();
    clr_in();
    for (int i = 0; i < 10; i++) begin
      bus.Branch = 1; bus.CondMet = 1; bus.Target = PC_W'($urandom);
      bus.Call = 1; bus.Ret = 1'($urandom_range(0, 1)); bus.Halt = 1;
      tick();
      n_checks++;
      if ({bus.ProgCtr, bus.Running, bus.Done, bus.StackErr} !== {8'd20, 3'b010}) begin
        n_err++;
        $display("FAIL halted[%0d]: got pc=%0d done=%b run=%b expected pc=20 done=1 run=0", i,
                 bus.ProgCtr, bus.Done, bus.Running);
      end
    end
    clr_in();
    bus.Start = 1;
    tick();
    clr_in();
    n_checks++;
    if ({bus.ProgCtr, bus.Running, bus.Done, bus.StackErr} !== {START_ADDR, 3'b100}) begin
      n_err++;
      $display("FAIL halt_restart: got pc=%0d run=%b done=%b expected pc=%0d run=1 done=0",
               bus.ProgCtr, bus.Running, bus.Done, START_ADDR);
    end
  endtask

  task automatic test_async_reset();
    go_to(33);
    #2;
    Reset = 0;
    #1;
    model_reset();
    n_checks++;
    if ({bus.ProgCtr, bus.Running, bus.Done, bus.StackErr} !== {START_ADDR, 3'b000}) begin
      n_err++;
      $display("FAIL async_reset: got pc=%0d flags=%b expected pc=%0d flags=000",
               bus.ProgCtr, {bus.Running, bus.Done, bus.StackErr}, START_ADDR);
    end
    tick();
    Reset = 1;
    tick();
    n_checks++;
    if ({bus.ProgCtr, bus.Running} !== {START_ADDR, 1'b0}) begin
      n_err++;
      $display("FAIL reset_release_idle: got pc=%0d run=%b expected pc=%0d run=0",
               bus.ProgCtr, bus.Running, START_ADDR);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      bus.Start    = ($urandom_range(0, 31) == 0);
      bus.Halt     = ($urandom_range(0, 23) == 0);
      bus.Stall    = ($urandom_range(0, 7) == 0);
      bus.Call     = ($urandom_range(0, 5) == 0);
      bus.Ret      = ($urandom_range(0, 5) == 0);
      bus.Branch   = ($urandom_range(0, 2) == 0);
      bus.CondMet  = 1'($urandom_range(0, 1));
      bus.Relative = 1'($urandom_range(0, 1));
      bus.Target   = PC_W'($urandom);
      bus.Offset   = OFS_W'($urandom);
      tick();
      n_checks++;
      if ({bus.ProgCtr, bus.Running, bus.Done, bus.StackErr} !== exp_vec()) begin
        n_err++;
        $display("FAIL random[%0d]: got pc=%0d run/done/err=%b expected pc=%0d run/done/err=%b", i,
                 bus.ProgCtr, {bus.Running, bus.Done, bus.StackErr},
                 exp_vec() >> 3, exp_vec() & 3'b111);
      end
    end
    clr_in();
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    test_reset();
    test_count();
    test_branch();
    test_wrap_stall();
    test_call();
    test_halt();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/prog_ctr_seq.md
Name: prog_ctr_seq

Overview:
- Parametrised next-generation program counter for the single-cycle core. It sits between the branch/control decode and instruction-memory address.
- Adds to the basic Start/Branch counter: configurable width, a reset/start vector, PC-relative branches, stall, a halt/done handshake, and an optional call/return stack.
- Exactly one PC update per rising Clk edge.

Parameters:
- PC_W, 8: program counter width in bits.
- OFS_W, 6: width of the signed relative-branch offset.
- START_ADDR, 0: value loaded into ProgCtr on reset and on Start.
- STACK_DEPTH, 4: return-stack entries. Must be a power of 2, ≥2. Used only with PROG_CTR_STACK_EN.

Ports:
- Clk  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  begin program; synchronous restart from any state.
- Stall  in  1  hold PC this cycle.
- Branch  in  1  branch instruction decoded.
- CondMet  in  1  branch condition true.
- Relative  in  1  1: target = PC + Offset; 0: target = Target.
- Target  in  PC_W  absolute branch/call target.
- Offset  in  OFS_W  signed relative offset.
- Call  in  1  call instruction (stack feature).
- Ret  in  1  return instruction (stack feature).
- Halt  in  1  halt instruction decoded.
- ProgCtr  out  PC_W  current instruction address.
- Running  out  1  FSM in RUN.
- Done  out  1  FSM in HALTED.
- StackErr  out  1  sticky stack over/underflow flag.

Behaviour:
- Reset low, asynchronous:
  - ProgCtr=START_ADDR, state=IDLE, Running=0, Done=0, StackErr=0, stack pointer=0.
  - A reset mid-operation discards all stack contents.
- FSM states IDLE, RUN, HALTED, ERR. All outputs are registered or decoded directly from the state register.
- IDLE:
  - ProgCtr held at START_ADDR.
  - Start → RUN, ProgCtr=START_ADDR.
- RUN, per edge, priority highest first:
  - Start: ProgCtr=START_ADDR, stack cleared, stay in RUN.
  - Halt: → HALTED, ProgCtr held.
  - Stall: ProgCtr held. Call/Ret/Branch are ignored this cycle (no push or pop).
  - Ret: ProgCtr=pop.
  - Call: push ProgCtr+1, ProgCtr=target.
  - Branch && CondMet: ProgCtr=target.
  - Otherwise: ProgCtr=ProgCtr+1.
- Target selection: if Relative, ProgCtr + sign-extend(Offset); otherwise Target.
- Arithmetic: all additions modulo 2^PC_W. Increment from all-ones wraps to 0. Relative wrap in either direction is legal and silent.
- Branch with CondMet=0: plain increment.
- Call and Ret both asserted: Ret wins, no push.
- HALTED:
  - Done=1, ProgCtr frozen, all inputs except Start ignored.
  - Start → RUN at START_ADDR, Done drops on the same edge.
- ERR:
  - Entered on push when the stack is full, or pop when it is empty.
  - StackErr=1, ProgCtr frozen at the offending instruction address.
  - Only Start (→ RUN, StackErr cleared, stack cleared) or Reset exit.
- Latency: every control input affects ProgCtr on the next edge. No combinational path from inputs to outputs.

Optional Feature:
- PROG_CTR_STACK_EN defined: LIFO return stack of STACK_DEPTH entries × PC_W bits, with over/underflow detection as above.
- Not defined:
  - Call acts as Branch with CondMet=1.
  - Ret is ignored (plain increment).
  - StackErr tied 0; ERR state unreachable.
  - No stack storage is synthesised.

Decomposition:
- Package prog_ctr_pkg: pc_state_e enum {IDLE, RUN, HALTED, ERR}; next-PC source enum {HOLD, INC, TGT, POP, START}.
- Sub-module ret_stack, instantiated under PROG_CTR_STACK_EN:
  - Inputs: push, pop, clr, din.
  - Outputs: dout, full, empty.
  - Same Clk/Reset.
- Top module holds the FSM and next-PC mux.

Test Plan:
- Start pulse, 5 idle cycles (PC_W=8) → ProgCtr 0,1,2,3,4,5; Running=1.
- At PC=10, Branch=1, CondMet=1, Relative=1, Offset=-4 → next ProgCtr=6. Repeat with CondMet=0 → 11.
- ProgCtr=255, no control → wraps to 0. Stall held 3 cycles at 7 → stays 7, then 8.
- Stack enabled:
  - Call Target=40 at PC=3 → PC=40, then Ret → PC=4.
  - Five nested calls with STACK_DEPTH=4 → 5th call enters ERR, StackErr=1, PC frozen.
  - Start → RUN at 0, StackErr=0.
- Halt at PC=20 → Done=1, PC=20 for 10 cycles despite Branch.
- Reset low mid-run at PC=33 → ProgCtr=START_ADDR and all flags 0 asynchronously, before the next Clk edge.
